// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline encodings used by the writeback stage.
//   RES_*  : result-source select codes carried down the pipeline.
//   F3_*   : load funct3 codes that pick width and extension of a load.
package riscv_pkg;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;
  localparam logic [1:0] RES_IMM  = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/writeback_stage_pipelined_load_extend.sv
// Combinational load extraction and sign/zero extension.
// Ports:
//   data     : raw aligned data-memory word (XLEN bits)
//   funct3   : load funct3 (LB/LH/LW/LD/LBU/LHU/LWU, 111 gives zero)
//   addr_low : byte offset of the load address
//   ext      : extracted and extended load value
module load_extend
  import riscv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      funct3,
  input  logic [2:0]      addr_low,
  output logic [XLEN-1:0] ext
);

  logic [2:0]      lane_s;
  logic [XLEN-1:0] byte_sh_s;
  logic [XLEN-1:0] half_sh_s;
  logic [XLEN-1:0] word_sh_s;

  // A 32-bit word has only four byte lanes, so the top offset bit is dropped.
  assign lane_s    = (XLEN == 64) ? addr_low : {1'b0, addr_low[1:0]};
  // Move the addressed lane down to bit 0; lower offset bits are ignored for wider accesses.
  assign byte_sh_s = data >> {lane_s, 3'b000};
  assign half_sh_s = data >> {lane_s[2:1], 4'b0000};
  assign word_sh_s = data >> {lane_s[2], 5'b00000};

  // Width selection and extension; the fill pattern is written first and the low field overlaid.
  always_comb begin
    ext = '0;
    case (funct3)
      F3_LB: begin
        ext      = {XLEN{byte_sh_s[7]}};
        ext[7:0] = byte_sh_s[7:0];
      end
      F3_LBU: begin
        ext      = '0;
        ext[7:0] = byte_sh_s[7:0];
      end
      F3_LH: begin
        ext       = {XLEN{half_sh_s[15]}};
        ext[15:0] = half_sh_s[15:0];
      end
      F3_LHU: begin
        ext       = '0;
        ext[15:0] = half_sh_s[15:0];
      end
      F3_LW: begin
        ext       = {XLEN{word_sh_s[31]}};
        ext[31:0] = word_sh_s[31:0];
      end
      // On a 32-bit datapath LD and LWU collapse to a plain LW.
      F3_LD: begin
        if (XLEN == 64) begin
          ext = data;
        end else begin
          ext       = {XLEN{word_sh_s[31]}};
          ext[31:0] = word_sh_s[31:0];
        end
      end
      F3_LWU: begin
        if (XLEN == 64) begin
          ext       = '0;
          ext[31:0] = word_sh_s[31:0];
        end else begin
          ext       = {XLEN{word_sh_s[31]}};
          ext[31:0] = word_sh_s[31:0];
        end
      end
      default: ext = '0;
    endcase
  end

endmodule

// File: rtl/writeback_stage_pipelined.sv
// Registered MEM/WB boundary: selects the writeback result (ALU, load,
// PC+4, immediate), extends loads, and counts retired instructions.
// Ports:
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   stall_i, flush_i  : hold all WB state / kill the captured instruction
//   *_m               : MEM-stage instruction fields and operands
//   valid_w, reg_write_w, rd_w, result_w : register-file write port and forwarding value
//   instret_o         : retired-instruction counter (wraps)
module writeback_stage_pipelined
  import riscv_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             valid_m,
  input  logic             reg_write_m,
  input  logic [4:0]       rd_m,
  input  logic [1:0]       result_src_m,
  input  logic [2:0]       load_funct3_m,
  input  logic [2:0]       addr_low_m,
  input  logic [XLEN-1:0]  alu_result_m,
  input  logic [XLEN-1:0]  read_data_m,
  input  logic [XLEN-1:0]  pc_plus4_m,
  input  logic [XLEN-1:0]  imm_m,
  output logic             valid_w,
  output logic             reg_write_w,
  output logic [4:0]       rd_w,
  output logic [XLEN-1:0]  result_w,
  output logic [CNT_W-1:0] instret_o
);

  logic [XLEN-1:0]  load_val_s;
  logic [XLEN-1:0]  result_s;
  logic             valid_r;
  logic             reg_write_r;
  logic [4:0]       rd_r;
  logic [XLEN-1:0]  result_r;
  logic [CNT_W-1:0] instret_r;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .data     (read_data_m),
    .funct3   (load_funct3_m),
    .addr_low (addr_low_m),
    .ext      (load_val_s)
  );

  // Result source select.
  always_comb begin
    result_s = alu_result_m;
    case (result_src_m)
      RES_ALU:  result_s = alu_result_m;
      RES_LOAD: result_s = load_val_s;
      RES_PC4:  result_s = pc_plus4_m;
      RES_IMM:  result_s = imm_m;
      default:  result_s = alu_result_m;
    endcase
  end

  // MEM/WB boundary registers; flush wins over stall and never counts a retirement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r     <= 1'b0;
      reg_write_r <= 1'b0;
      rd_r        <= 5'd0;
      result_r    <= '0;
      instret_r   <= '0;
    end else if (flush_i) begin
      valid_r     <= 1'b0;
      reg_write_r <= 1'b0;
      rd_r        <= rd_m;
      result_r    <= result_s;
    end else if (!stall_i) begin
      valid_r     <= valid_m;
      // x0 is hardwired to zero, so a write to it is never requested.
      reg_write_r <= valid_m & reg_write_m & (rd_m != 5'd0);
      rd_r        <= rd_m;
      result_r    <= result_s;
      if (valid_m) begin
        instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        instret_r <= instret_r;
      end
    end else begin
      valid_r     <= valid_r;
      reg_write_r <= reg_write_r;
      rd_r        <= rd_r;
      result_r    <= result_r;
      instret_r   <= instret_r;
    end
  end

  assign valid_w     = valid_r;
  assign reg_write_w = reg_write_r;
  assign rd_w        = rd_r;
  assign result_w    = result_r;
  assign instret_o   = instret_r;

endmodule

// File: tb/tb_writeback_stage_pipelined.sv
// Directed bench for writeback_stage_pipelined (XLEN=64, CNT_W=4 so the
// counter wrap is reachable). Expected W-stage state is pushed to a queue
// when a step is driven and popped/compared one edge later.
module tb_writeback_stage_pipelined;

  localparam int XLEN  = 64;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             stall_i, flush_i, valid_m, reg_write_m;
  logic [4:0]       rd_m;
  logic [1:0]       result_src_m;
  logic [2:0]       load_funct3_m, addr_low_m;
  logic [XLEN-1:0]  alu_result_m, read_data_m, pc_plus4_m, imm_m;
  logic             valid_w, reg_write_w;
  logic [4:0]       rd_w;
  logic [XLEN-1:0]  result_w;
  logic [CNT_W-1:0] instret_o;

  writeback_stage_pipelined #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .valid_m(valid_m), .reg_write_m(reg_write_m), .rd_m(rd_m),
    .result_src_m(result_src_m), .load_funct3_m(load_funct3_m),
    .addr_low_m(addr_low_m), .alu_result_m(alu_result_m),
    .read_data_m(read_data_m), .pc_plus4_m(pc_plus4_m), .imm_m(imm_m),
    .valid_w(valid_w), .reg_write_w(reg_write_w), .rd_w(rd_w),
    .result_w(result_w), .instret_o(instret_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        rw;
    logic [4:0]  rd;
    logic [63:0] res;
    logic [3:0]  cnt;
  } exp_t;

  exp_t sb[$];
  exp_t m;          // model of the W-stage state
  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [63:0] RDATA = 64'h8877_6655_4433_2211;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"},   {63'd0, valid_w},     64'd0);
    chk({tag, ".rw"},      {63'd0, reg_write_w}, 64'd0);
    chk({tag, ".rd"},      {59'd0, rd_w},        64'd0);
    chk({tag, ".result"},  result_w,             64'd0);
    chk({tag, ".instret"}, {60'd0, instret_o},   64'd0);
  endtask

  task automatic clear_model();
    m.v = 1'b0; m.rw = 1'b0; m.rd = 5'd0; m.res = 64'd0; m.cnt = 4'd0;
  endtask

  // One pipeline step: drive M inputs, predict W state, clock, compare.
  // res is the value the bench expects the selected source to produce.
  task automatic step(input string tag, input logic v, input logic rw,
                      input logic [4:0] rd, input logic [1:0] src,
                      input logic [2:0] f3, input logic [2:0] al,
                      input logic [63:0] alu, input logic [63:0] pc4,
                      input logic [63:0] imm, input logic st, input logic fl,
                      input logic [63:0] res);
    exp_t e;
    valid_m = v; reg_write_m = rw; rd_m = rd; result_src_m = src;
    load_funct3_m = f3; addr_low_m = al; alu_result_m = alu;
    read_data_m = RDATA; pc_plus4_m = pc4; imm_m = imm;
    stall_i = st; flush_i = fl;
    if (fl) begin
      m.v = 1'b0; m.rw = 1'b0; m.rd = rd; m.res = res;
    end else if (!st) begin
      m.v = v; m.rd = rd; m.res = res;
      m.rw = v && rw && (rd != 5'd0);
      if (v) m.cnt = m.cnt + 4'd1;
    end
    sb.push_back(m);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, ".valid"},   {63'd0, valid_w},     {63'd0, e.v});
      chk({tag, ".rw"},      {63'd0, reg_write_w}, {63'd0, e.rw});
      chk({tag, ".rd"},      {59'd0, rd_w},        {59'd0, e.rd});
      chk({tag, ".result"},  result_w,             e.res);
      chk({tag, ".instret"}, {60'd0, instret_o},   {60'd0, e.cnt});
    end
  endtask

  initial begin
    // Reset with random inputs.
    rst_n = 1'b0;
    stall_i = 1'b0; flush_i = 1'b0;
    valid_m = 1'b1; reg_write_m = 1'b1; rd_m = 5'($urandom);
    result_src_m = 2'($urandom); load_funct3_m = 3'($urandom);
    addr_low_m = 3'($urandom);
    alu_result_m = {$urandom, $urandom}; read_data_m = {$urandom, $urandom};
    pc_plus4_m = {$urandom, $urandom}; imm_m = {$urandom, $urandom};
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();

    // Loads: v, rw, rd, src, f3, addr, alu, pc4, imm, stall, flush, expected.
    step("lb7",  1'b1, 1'b1, 5'd3, 2'b01, 3'b000, 3'd7, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FF88);
    step("lbu7", 1'b1, 1'b1, 5'd3, 2'b01, 3'b100, 3'd7, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 64'h0000_0000_0000_0088);
    step("lh6",  1'b1, 1'b1, 5'd3, 2'b01, 3'b001, 3'd6, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_8877);
    step("lw0",  1'b1, 1'b1, 5'd3, 2'b01, 3'b010, 3'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 64'h0000_0000_4433_2211);
    step("lwu4", 1'b1, 1'b1, 5'd3, 2'b01, 3'b110, 3'd4, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 64'h0000_0000_8877_6655);
    step("ld",   1'b1, 1'b1, 5'd3, 2'b01, 3'b011, 3'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 64'h8877_6655_4433_2211);
    step("lw4",  1'b1, 1'b1, 5'd3, 2'b01, 3'b010, 3'd5, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 64'hFFFF_FFFF_8877_6655);
    step("lhu3", 1'b1, 1'b1, 5'd3, 2'b01, 3'b101, 3'd3, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 64'h0000_0000_0000_4433);
    step("lb1",  1'b1, 1'b1, 5'd3, 2'b01, 3'b000, 3'd1, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 64'h0000_0000_0000_0022);
    step("f3_7", 1'b1, 1'b1, 5'd3, 2'b01, 3'b111, 3'd2, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0);

    // Source select, rd=5.
    step("alu",  1'b1, 1'b1, 5'd5, 2'b00, 3'b011, 3'd0, 64'h10, 64'h1004, 64'h1234_5000, 1'b0, 1'b0, 64'h10);
    step("pc4",  1'b1, 1'b1, 5'd5, 2'b10, 3'b011, 3'd0, 64'h10, 64'h1004, 64'h1234_5000, 1'b0, 1'b0, 64'h1004);
    step("imm",  1'b1, 1'b1, 5'd5, 2'b11, 3'b011, 3'd0, 64'h10, 64'h1004, 64'h1234_5000, 1'b0, 1'b0, 64'h1234_5000);

    // x0 and valid gating.
    step("x0",     1'b1, 1'b1, 5'd0, 2'b00, 3'b000, 3'd0, 64'h77, 64'd0, 64'd0, 1'b0, 1'b0, 64'h77);
    step("invld",  1'b0, 1'b1, 5'd9, 2'b00, 3'b000, 3'd0, 64'h99, 64'd0, 64'd0, 1'b0, 1'b0, 64'h99);
    step("pre_st", 1'b1, 1'b1, 5'd7, 2'b00, 3'b000, 3'd0, 64'hAA, 64'd0, 64'd0, 1'b0, 1'b0, 64'hAA);

    // Three stall cycles with changing inputs: everything holds.
    step("stall1", 1'b1, 1'b1, 5'd8,  2'b00, 3'b000, 3'd0, 64'hB1, 64'd0, 64'd0, 1'b1, 1'b0, 64'hB1);
    step("stall2", 1'b1, 1'b1, 5'd9,  2'b10, 3'b000, 3'd0, 64'hB2, 64'hC2, 64'd0, 1'b1, 1'b0, 64'hC2);
    step("stall3", 1'b1, 1'b0, 5'd10, 2'b01, 3'b011, 3'd0, 64'hB3, 64'd0, 64'd0, 1'b1, 1'b0, RDATA);

    // Stall and flush together: flush wins, no count.
    step("st_fl",  1'b1, 1'b1, 5'd11, 2'b00, 3'b000, 3'd0, 64'hD1, 64'd0, 64'd0, 1'b1, 1'b1, 64'hD1);
    step("flush",  1'b1, 1'b1, 5'd12, 2'b11, 3'b000, 3'd0, 64'd0, 64'd0, 64'hE000, 1'b0, 1'b1, 64'hE000);
    step("release",1'b1, 1'b1, 5'd13, 2'b00, 3'b000, 3'd0, 64'hF1, 64'd0, 64'd0, 1'b0, 1'b0, 64'hF1);

    // Asynchronous reset mid-cycle while stalled: outputs clear before any edge.
    stall_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    stall_i = 1'b0;
    clear_model();

    // 17 retirements on a 4-bit counter wraps to 1.
    for (int i = 0; i < 17; i++) begin
      step("wrap", 1'b1, 1'b1, 5'd1, 2'b00, 3'b000, 3'd0, 64'(i), 64'd0, 64'd0, 1'b0, 1'b0, 64'(i));
    end
    chk("wrap_final", {60'd0, instret_o}, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/writeback_stage_pipelined.md
Name: writeback_stage_pipelined

Overview:
Parametrised successor to the combinational writeback mux. It adds a registered MEM/WB boundary with valid/stall/flush control and RISC-V load extraction and sign/zero extension by funct3 and byte offset. It also adds a fourth result source (immediate, for LUI) and a retired-instruction counter. It sits between the memory stage and the register file and drives the register-file write port and the WB forwarding path.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64.
CNT_W, 64, width of the retired-instruction counter.

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
stall_i  input  1  hold all WB registers
flush_i  input  1  kill the instruction being captured
valid_m  input  1  MEM-stage instruction valid
reg_write_m  input  1  MEM-stage register-write enable
rd_m  input  5  MEM-stage destination register
result_src_m  input  2  result select: 00 ALU, 01 load, 10 PC+4, 11 IMM
load_funct3_m  input  3  000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU
addr_low_m  input  3  byte offset of the load address (ALU_Result[2:0])
alu_result_m  input  XLEN  ALU result
read_data_m  input  XLEN  raw aligned data-memory word
pc_plus4_m  input  XLEN  PC+4
imm_m  input  XLEN  U-type immediate
valid_w  output  1  WB instruction valid
reg_write_w  output  1  register-file write enable
rd_w  output  5  register-file write address
result_w  output  XLEN  register-file write data, also the forwarding value
instret_o  output  CNT_W  retired-instruction count

Behaviour:
- Reset (rst_n=0, asynchronous): valid_w=0, reg_write_w=0, rd_w=0, result_w=0, instret_o=0. Reset takes effect immediately regardless of clk, including mid-stall.
- The result mux and load extraction are combinational on M-stage inputs. The result is registered: one-cycle latency from M inputs to W outputs.
- Load extraction, using byte lane = addr_low_m:
  - LB/LBU: byte at offset addr_low_m[2:0].
  - LH/LHU: halfword at addr_low_m[2:1]*2; addr_low_m[0] ignored.
  - LW/LWU: word at addr_low_m[2]*4; addr_low_m[1:0] ignored.
  - LD: full XLEN.
  - LB/LH/LW sign-extend to XLEN; LBU/LHU/LWU zero-extend.
  - XLEN=32: addr_low_m[2] ignored; LD and LWU behave as LW.
  - funct3 111: load value = 0.
- Register update each rising edge, in priority order:
  1. flush_i=1: valid_w<=0, reg_write_w<=0. rd_w and result_w still load. flush overrides stall.
  2. stall_i=1: all W registers and instret_o hold.
  3. Otherwise: valid_w<=valid_m; rd_w<=rd_m; result_w<=selected result; reg_write_w<=valid_m & reg_write_m & (rd_m!=0).
- The x0 rule: reg_write_w is never 1 with rd_w=0.
- instret_o increments by 1 on an edge where valid_m=1, stall_i=0 and flush_i=0. The new value is visible in the same cycle valid_w rises. It wraps modulo 2^CNT_W with no saturation.
- Simultaneous stall and flush: treated as flush; no increment.
- Unknown result_src_m values cannot occur with a 2-bit field, so all four encodings are defined.

Decomposition:
- Shared package (riscv_pkg): the RES_ALU/RES_LOAD/RES_PC4/RES_IMM encodings and the F3_LB..F3_LWU load funct3 constants.
- One natural sub-module: load_extend (combinational; inputs XLEN data, funct3, addr_low; output extended value). It is reusable by a future misaligned-load handler.
- The existing Mux4x1 can serve as the result mux when XLEN=64.

Test Plan:
- Reset: hold rst_n=0 with random inputs, then deassert → all outputs 0; assert rst_n=0 asynchronously mid-cycle → outputs 0 before the next edge.
- Load extension (XLEN=64), read_data_m=0x8877_6655_4433_2211:
  - LB, addr 7 → 0xFFFF_FFFF_FFFF_FF88
  - LBU, addr 7 → 0x88
  - LH, addr 6 → 0xFFFF_FFFF_FFFF_8877
  - LW, addr 0 → 0x4433_2211
  - LWU, addr 4 → 0x8877_6655
  - LD → full word
  Each appears on result_w one cycle after it is applied.
- Source select: ALU=0x10, PC+4=0x1004, IMM=0x12345000 with srcs 00/10/11 → result_w = 0x10, 0x1004, 0x12345000 on consecutive cycles; reg_write_w=1 with rd=5.
- x0 and valid gating: rd_m=0 with reg_write_m=1 → reg_write_w=0, instret increments. valid_m=0 → reg_write_w=0, instret unchanged.
- Stall and flush:
  - 3 stall cycles → outputs and instret hold.
  - stall=1 and flush=1 together → valid_w=0, reg_write_w=0, instret unchanged.
  - Release → next instruction captured normally.
- Counter wrap (CNT_W=4): 17 valid retirements → instret_o=1.
